// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and helpers for the write-through byte cache
package cache_pkg;

    typedef enum logic [1:0] {
        READY,
        TAG_CHECK,
        REFILL,
        WRITE_MEM
    } state_t;

    // Upper bound for the byte-merge helper; callers size-cast in and out.
    localparam int LINE_W_MAX = 1024;

    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int line_width(input int offset_w);
        return 8 * (1 << offset_w);
    endfunction

    function automatic logic [LINE_W_MAX-1:0] merge_byte(
        input logic [LINE_W_MAX-1:0] line,
        input int unsigned           offset,
        input logic [7:0]            wbyte
    );
        logic [LINE_W_MAX-1:0] merged;
        merged                  = line;
        merged[offset*8 +: 8]   = wbyte;
        return merged;
    endfunction

endpackage

// File: rtl/cache_line_ram.sv
// rtl/cache_line_ram.sv - line store with synchronous write-first read and clearable valid bits
module cache_line_ram #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 5,
    parameter int LINE_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic              wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data
);
    localparam int DEPTH = 1 << INDEX_W;

    logic [TAG_W+LINE_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]        valid;
    logic                    bypass;

    assign bypass = wr_en && (wr_index == rd_index);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index] <= {wr_tag, wr_data};
        end
        if (bypass) begin
            {rd_tag, rd_data} <= {wr_tag, wr_data};
        end else begin
            {rd_tag, rd_data} <= mem[rd_index];
        end
    end

    // Only the valid vector is reset; stale tag/data is masked by it.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                valid[wr_index] <= 1'b1;
            end
            rd_valid <= bypass ? 1'b1 : valid[rd_index];
        end
    end

endmodule

// File: rtl/cache_wt.sv
// rtl/cache_wt.sv - direct-mapped write-through no-write-allocate byte cache (optional CACHE_STATS_EN counters)
module cache_wt
    import cache_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_W-1:0]                  addr_from_cpu,
    input  logic                               rreq_from_cpu,
    input  logic                               wreq_from_cpu,
    input  logic [7:0]                         wdata_from_cpu,
    input  logic [cache_pkg::line_width(OFFSET_W)-1:0] rdata_from_mem,
    input  logic                               rvalid_from_mem,
    input  logic                               wack_from_mem,
    output logic [7:0]                         rdata_to_cpu,
    output logic                               hit_to_cpu,
    output logic                               wdone_to_cpu,
    output logic                               rreq_to_mem,
    output logic [ADDR_W-1:0]                  raddr_to_mem,
    output logic                               wreq_to_mem,
    output logic [ADDR_W-1:0]                  waddr_to_mem,
    output logic [7:0]                         wdata_to_mem
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                        hit_cnt,
    output logic [31:0]                        miss_cnt
`endif
);
    localparam int TAG_W  = tag_width(ADDR_W, INDEX_W, OFFSET_W);
    localparam int LINE_W = line_width(OFFSET_W);

    state_t state, state_next;

    logic                op_write;
    logic [INDEX_W-1:0]  idx_q;
    logic [TAG_W-1:0]    cur_tag;
    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] cur_off;
    logic [INDEX_W-1:0]  rd_index;

    logic                ram_we;
    logic [LINE_W-1:0]   ram_wdata;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_data;
    logic                line_hit;
    logic [LINE_W_MAX-1:0] merged_full;

    assign cur_tag    = addr_from_cpu[ADDR_W-1 -: TAG_W];
    assign addr_index = addr_from_cpu[OFFSET_W +: INDEX_W];
    assign cur_off    = addr_from_cpu[OFFSET_W-1:0];

    // The store is read every cycle so the refill write lands in the TAG_CHECK recheck.
    assign rd_index = (state == READY) ? addr_index : idx_q;
    assign line_hit = rd_valid && (rd_tag == cur_tag);

    assign merged_full = merge_byte(LINE_W_MAX'(rd_data), 32'(cur_off), wdata_from_cpu);

    cache_line_ram #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .LINE_W  (LINE_W)
    ) u_line_ram (
        .clk      (clk),
        .reset    (reset),
        .rd_index (rd_index),
        .wr_en    (ram_we),
        .wr_index (idx_q),
        .wr_tag   (cur_tag),
        .wr_data  (ram_wdata),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= READY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        hit_to_cpu   = 1'b0;
        rdata_to_cpu = 8'h00;
        ram_we       = 1'b0;
        ram_wdata    = rdata_from_mem;
        case (state)
            READY: begin
                // A held request is not resampled during the write completion pulse.
                if (!wdone_to_cpu && (wreq_from_cpu || rreq_from_cpu)) begin
                    state_next = TAG_CHECK;
                end
            end
            TAG_CHECK: begin
                if (op_write) begin
                    if (line_hit) begin
                        ram_we    = 1'b1;
                        ram_wdata = merged_full[LINE_W-1:0];
                    end
                    state_next = WRITE_MEM;
                end else if (line_hit) begin
                    hit_to_cpu   = 1'b1;
                    rdata_to_cpu = rd_data[{cur_off, 3'b000} +: 8];
                    state_next   = READY;
                end else begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                if (rvalid_from_mem) begin
                    ram_we     = 1'b1;
                    ram_wdata  = rdata_from_mem;
                    state_next = TAG_CHECK;
                end
            end
            WRITE_MEM: begin
                if (wack_from_mem) begin
                    state_next = READY;
                end
            end
            default: state_next = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_write     <= 1'b0;
            idx_q        <= '0;
            rreq_to_mem  <= 1'b0;
            raddr_to_mem <= '0;
            wreq_to_mem  <= 1'b0;
            waddr_to_mem <= '0;
            wdata_to_mem <= 8'h00;
            wdone_to_cpu <= 1'b0;
        end else begin
            wdone_to_cpu <= (state == WRITE_MEM) && wack_from_mem;
            if (state == READY && state_next == TAG_CHECK) begin
                op_write <= wreq_from_cpu;
                idx_q    <= addr_index;
            end
            if (state == TAG_CHECK && state_next == REFILL) begin
                rreq_to_mem  <= 1'b1;
                raddr_to_mem <= {cur_tag, idx_q, {OFFSET_W{1'b0}}};
            end
            if (state == REFILL && rvalid_from_mem) begin
                rreq_to_mem  <= 1'b0;
                raddr_to_mem <= '0;
            end
            if (state == TAG_CHECK && state_next == WRITE_MEM) begin
                wreq_to_mem  <= 1'b1;
                waddr_to_mem <= addr_from_cpu;
                wdata_to_mem <= wdata_from_cpu;
            end
            if (state == WRITE_MEM && wack_from_mem) begin
                wreq_to_mem  <= 1'b0;
                waddr_to_mem <= '0;
                wdata_to_mem <= 8'h00;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic refilled;

    // The post-refill recheck is a guaranteed hit and must not count as one.
    always_ff @(posedge clk) begin
        if (reset) begin
            refilled <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == READY) begin
                refilled <= 1'b0;
            end else if (state == REFILL && rvalid_from_mem) begin
                refilled <= 1'b1;
            end
            if (state == TAG_CHECK && !op_write) begin
                if (line_hit && !refilled && hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
                if (!line_hit && miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule
